// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: sequencing states,
// forwarding-select encodings and the hard-wired zero register.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    REPLAY = 2'd2
  } hazard_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a writing stage targets src; register 0 never matches.
  function automatic logic dst_hit(input logic       wr_en,
                                   input logic [4:0] dst,
                                   input logic [4:0] src);
    return wr_en && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one EX source operand. The youngest producer
// (EX_MEM) wins over the older one (MEM_WB).
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       mem_reg_write_i,
  input  logic [4:0] mem_dst_i,
  input  logic       wb_reg_write_i,
  input  logic [4:0] wb_dst_i,
  output logic [1:0] fwd_sel_o
);

  // Pick the nearest pipeline stage that will write this operand.
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (dst_hit(mem_reg_write_i, mem_dst_i, src_i)) begin
      fwd_sel_o = FWD_MEM;
    end else if (dst_hit(wb_reg_write_i, wb_dst_i, src_i)) begin
      fwd_sel_o = FWD_WB;
    end else begin
      fwd_sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: forwarding,
// load-use stalls, branch/jump redirects, and memory-wait freeze with a
// deferred redirect replay. Optional performance counters are built when
// PIPELINE_HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [31:0]      id_jump_target,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dst,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_dst,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_dst,
  input  logic             mem_wait,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
`ifdef PIPELINE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] freeze_cycles
`endif
);

  hazard_state_e state_q, state_d;
  logic          pending_q, pending_d;
  logic [31:0]   pending_pc_q, pending_pc_d;

  logic          load_use_s;
  logic [1:0]    fwd_a_s, fwd_b_s;
  logic          pc_stall_s, if_id_stall_s, id_ex_stall_s, ex_mem_stall_s;
  logic          if_id_flush_s, id_ex_flush_s, mem_wb_flush_s;
  logic          redirect_valid_s;
  logic [31:0]   redirect_pc_s;

  forward_unit u_fwd_a (
    .src_i           (ex_rs),
    .mem_reg_write_i (mem_reg_write),
    .mem_dst_i       (mem_dst),
    .wb_reg_write_i  (wb_reg_write),
    .wb_dst_i        (wb_dst),
    .fwd_sel_o       (fwd_a_s)
  );

  forward_unit u_fwd_b (
    .src_i           (ex_rt),
    .mem_reg_write_i (mem_reg_write),
    .mem_dst_i       (mem_dst),
    .wb_reg_write_i  (wb_reg_write),
    .wb_dst_i        (wb_dst),
    .fwd_sel_o       (fwd_b_s)
  );

  // Load in EX whose destination is a source the ID instruction really reads.
  always_comb begin
    load_use_s = 1'b0;
    if (ex_mem_read && (ex_dst != REG_ZERO)) begin
      load_use_s = (id_uses_rs && (id_rs == ex_dst)) ||
                   (id_uses_rt && (id_rt == ex_dst));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Sequencing decisions and next-state for RUN / FREEZE / REPLAY.
  always_comb begin
    state_d          = state_q;
    pending_d        = pending_q;
    pending_pc_d     = pending_pc_q;
    pc_stall_s       = 1'b0;
    if_id_stall_s    = 1'b0;
    id_ex_stall_s    = 1'b0;
    ex_mem_stall_s   = 1'b0;
    if_id_flush_s    = 1'b0;
    id_ex_flush_s    = 1'b0;
    mem_wb_flush_s   = 1'b0;
    redirect_valid_s = 1'b0;
    redirect_pc_s    = 32'd0;

    case (state_q)
      RUN: begin
        if (mem_wait) begin
          // A redirect seen now is parked and replayed after the freeze.
          state_d = FREEZE;
          if (ex_branch_taken) begin
            pending_d    = 1'b1;
            pending_pc_d = ex_branch_target;
          end else if (id_jump) begin
            pending_d    = 1'b1;
            pending_pc_d = id_jump_target;
          end else begin
            pending_d    = 1'b0;
          end
        end else if (ex_branch_taken) begin
          redirect_valid_s = 1'b1;
          redirect_pc_s    = ex_branch_target;
          if_id_flush_s    = 1'b1;
          id_ex_flush_s    = 1'b1;
        end else if (load_use_s) begin
          pc_stall_s    = 1'b1;
          if_id_stall_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end else if (id_jump) begin
          redirect_valid_s = 1'b1;
          redirect_pc_s    = id_jump_target;
          if_id_flush_s    = 1'b1;
        end else begin
          state_d = RUN;
        end
      end

      FREEZE: begin
        pc_stall_s     = 1'b1;
        if_id_stall_s  = 1'b1;
        id_ex_stall_s  = 1'b1;
        ex_mem_stall_s = 1'b1;
        mem_wb_flush_s = 1'b1;
        if (!mem_wait) begin
          state_d = pending_q ? REPLAY : RUN;
        end else begin
          state_d = FREEZE;
        end
      end

      REPLAY: begin
        // The parked redirect always completes, even if mem_wait rises now.
        redirect_valid_s = 1'b1;
        redirect_pc_s    = pending_pc_q;
        if_id_flush_s    = 1'b1;
        id_ex_flush_s    = 1'b1;
        pending_d        = 1'b0;
        state_d          = mem_wait ? FREEZE : RUN;
      end

      default: begin
        state_d   = RUN;
        pending_d = 1'b0;
      end
    endcase
  end

  // Outputs are forced low while reset is held so they drop asynchronously.
  always_comb begin
    if (!reset) begin
      pc_stall       = 1'b0;
      if_id_stall    = 1'b0;
      id_ex_stall    = 1'b0;
      ex_mem_stall   = 1'b0;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      mem_wb_flush   = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      fwd_a          = FWD_RF;
      fwd_b          = FWD_RF;
    end else begin
      pc_stall       = pc_stall_s;
      if_id_stall    = if_id_stall_s;
      id_ex_stall    = id_ex_stall_s;
      ex_mem_stall   = ex_mem_stall_s;
      if_id_flush    = if_id_flush_s;
      id_ex_flush    = id_ex_flush_s;
      mem_wb_flush   = mem_wb_flush_s;
      redirect_valid = redirect_valid_s;
      redirect_pc    = redirect_pc_s;
      fwd_a          = fwd_a_s;
      fwd_b          = fwd_b_s;
    end
  end

  // Sequencing state, pending flag and parked redirect target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      pending_q    <= 1'b0;
      pending_pc_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
    end
  end

`ifdef PIPELINE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  // Free-running event counters; they wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= {CNT_W{1'b0}};
      flush_cnt_q  <= {CNT_W{1'b0}};
      freeze_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (pc_stall) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (redirect_valid) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
      if (state_q == FREEZE) begin
        freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
      end else begin
        freeze_cnt_q <= freeze_cnt_q;
      end
    end
  end

  assign stall_cycles  = stall_cnt_q;
  assign flush_events  = flush_cnt_q;
  assign freeze_cycles = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run, all compared against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic        id_uses_rs, id_uses_rt, id_jump, ex_mem_read, ex_branch_taken;
  logic        mem_reg_write, wb_reg_write, mem_wait;
  logic [31:0] id_jump_target, ex_branch_target;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  fwd_a, fwd_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: "frozen", "replay owed this cycle", and a parked target.
  logic        m_frozen, m_replay_now, m_has_owed;
  logic [31:0] m_owed_pc;
  logic [43:0] got, exp_v;

  always #5 clk = ~clk;

  assign got = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
                id_ex_flush, mem_wb_flush, redirect_valid, redirect_pc, fwd_a, fwd_b};

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .mem_wait(mem_wait),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src != 5'd0 && mem_reg_write && mem_dst == src) return 2'd1;
    if (src != 5'd0 && wb_reg_write && wb_dst == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [43:0] model_expect();
    logic [3:0]  st;
    logic [2:0]  fl;
    logic        rv, lu;
    logic [31:0] rpc;
    st = 4'b0000; fl = 3'b000; rv = 1'b0; rpc = 32'd0;
    lu = ex_mem_read && ex_dst != 5'd0 &&
         ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
    if (!reset) return 44'd0;
    if (m_replay_now) begin
      rv = 1'b1; rpc = m_owed_pc; fl = 3'b110;
    end else if (m_frozen) begin
      st = 4'b1111; fl = 3'b001;
    end else if (mem_wait) begin
      st = 4'b0000;
    end else if (ex_branch_taken) begin
      rv = 1'b1; rpc = ex_branch_target; fl = 3'b110;
    end else if (lu) begin
      st = 4'b1100; fl = 3'b010;
    end else if (id_jump) begin
      rv = 1'b1; rpc = id_jump_target; fl = 3'b100;
    end
    return {st, fl, rv, rpc, ref_fwd(ex_rs), ref_fwd(ex_rt)};
  endfunction

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_edge();
    if (!reset) begin
      m_frozen = 1'b0; m_replay_now = 1'b0; m_has_owed = 1'b0; m_owed_pc = 32'd0;
    end else if (m_replay_now) begin
      m_replay_now = 1'b0; m_has_owed = 1'b0; m_frozen = mem_wait;
    end else if (m_frozen) begin
      if (!mem_wait) begin
        m_frozen = 1'b0; m_replay_now = m_has_owed;
      end
    end else if (mem_wait) begin
      m_frozen = 1'b1;
      m_has_owed = ex_branch_taken || id_jump;
      if (ex_branch_taken) m_owed_pc = ex_branch_target;
      else if (id_jump) m_owed_pc = id_jump_target;
    end
  endtask

  task automatic settle();
    #2;
    exp_v = model_expect();
    vectors++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_jump = 1'b0; id_jump_target = 32'd0; ex_rs = 5'd0; ex_rt = 5'd0;
    ex_mem_read = 1'b0; ex_dst = 5'd0; ex_branch_taken = 1'b0;
    ex_branch_target = 32'd0; mem_reg_write = 1'b0; mem_dst = 5'd0;
    wb_reg_write = 1'b0; wb_dst = 5'd0; mem_wait = 1'b0;
  endtask

  task automatic drive_random();
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
    ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
    ex_dst = 5'($urandom_range(0, 3)); mem_dst = 5'($urandom_range(0, 3));
    wb_dst = 5'($urandom_range(0, 3));
    id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
    ex_mem_read = ($urandom_range(0, 2) == 0);
    mem_reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
    ex_branch_taken = ($urandom_range(0, 4) == 0);
    id_jump = ($urandom_range(0, 4) == 0);
    ex_branch_target = $urandom() & 32'hFFFF_FFFC;
    id_jump_target = $urandom() & 32'hFFFF_FFFC;
    mem_wait = ($urandom_range(0, 4) == 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      ex_branch_taken = 1'b1;
      settle();
      if (got !== 44'd0 || exp_v !== 44'd0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %h expected %h", got, 44'd0);
      end
      next_cycle();
    end
    reset = 1'b1;
    drive_idle();
    settle();
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", got, exp_v);
    end
    next_cycle();
  endtask

  task automatic test_forwarding();
    drive_idle();
    ex_rs = 5'd1; mem_reg_write = 1'b1; mem_dst = 5'd1;
    wb_reg_write = 1'b1; wb_dst = 5'd1;
    settle();
    if (fwd_a !== 2'd1 || got !== exp_v) begin
      miscompares++;
      $display("FAIL fwd_mem: got %h expected %h", got, exp_v);
    end
    next_cycle();
    mem_reg_write = 1'b0; ex_rt = 5'd1;
    settle();
    if (fwd_a !== 2'd2 || fwd_b !== 2'd2 || got !== exp_v) begin
      miscompares++;
      $display("FAIL fwd_wb: got %h expected %h", got, exp_v);
    end
    next_cycle();
    ex_rs = 5'd0; ex_rt = 5'd0; mem_reg_write = 1'b1; mem_dst = 5'd0; wb_dst = 5'd0;
    settle();
    if (fwd_a !== 2'd0 || fwd_b !== 2'd0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL fwd_reg0: got %h expected %h", got, exp_v);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    drive_idle();
    ex_mem_read = 1'b1; ex_dst = 5'd2;
    id_rs = 5'd2; id_rt = 5'd4; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    settle();
    if ({pc_stall, if_id_stall, id_ex_flush, id_ex_stall, redirect_valid} !== 5'b11100 ||
        got !== exp_v) begin
      miscompares++;
      $display("FAIL load_use_stall: got %h expected %h", got, exp_v);
    end
    next_cycle();
    drive_idle();
    ex_rs = 5'd2; ex_rt = 5'd4; wb_reg_write = 1'b1; wb_dst = 5'd2;
    settle();
    if (fwd_a !== 2'd2 || pc_stall !== 1'b0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL load_use_fwd: got %h expected %h", got, exp_v);
    end
    next_cycle();
  endtask

  task automatic test_branch_over_load_use();
    drive_idle();
    ex_mem_read = 1'b1; ex_dst = 5'd2; id_rs = 5'd2; id_uses_rs = 1'b1;
    ex_branch_taken = 1'b1; ex_branch_target = 32'h40;
    settle();
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h40 || if_id_flush !== 1'b1 ||
        id_ex_flush !== 1'b1 || pc_stall !== 1'b0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL branch_priority: got %h expected %h", got, exp_v);
    end
    next_cycle();
  endtask

  task automatic test_freeze_replay();
    int freeze_seen;
    freeze_seen = 0;
    drive_idle();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h80; mem_wait = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) mem_wait = 1'b0;
      if (c == 4) ex_branch_taken = 1'b0;
      settle();
      if (mem_wb_flush === 1'b1 && {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} === 4'hF)
        freeze_seen++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL freeze_cycle%0d: got %h expected %h", c, got, exp_v);
      end
      if (c == 4 && (redirect_valid !== 1'b1 || redirect_pc !== 32'h80)) begin
        miscompares++;
        $display("FAIL replay_redirect: got %h expected 1/00000080", got);
      end
      next_cycle();
    end
    vectors++;
    if (freeze_seen != 3) begin
      miscompares++;
      $display("FAIL freeze_length: got %0d expected 3", freeze_seen);
    end
  endtask

  task automatic test_jump();
    drive_idle();
    id_jump = 1'b1; id_jump_target = 32'h100;
    settle();
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100 || if_id_flush !== 1'b1 ||
        id_ex_flush !== 1'b0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL jump_redirect: got %h expected %h", got, exp_v);
    end
    next_cycle();
    id_jump = 1'b0;
    settle();
    if (redirect_valid !== 1'b0 || if_id_flush !== 1'b0 || got !== exp_v) begin
      miscompares++;
      $display("FAIL jump_one_cycle: got %h expected %h", got, exp_v);
    end
    next_cycle();
  endtask

  task automatic test_reset_in_freeze();
    drive_idle();
    ex_branch_taken = 1'b1; ex_branch_target = 32'hC0; mem_wait = 1'b1;
    next_cycle();
    settle();
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL pre_reset_freeze: got %h expected %h", got, exp_v);
    end
    reset = 1'b0;
    settle();
    if (got !== 44'd0) begin
      miscompares++;
      $display("FAIL async_reset_freeze: got %h expected %h", got, 44'd0);
    end
    next_cycle();
    reset = 1'b1;
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      settle();
      if (redirect_valid !== 1'b0 || got !== exp_v) begin
        miscompares++;
        $display("FAIL no_replay_after_reset: got %h expected %h", got, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive_random();
      reset = ($urandom_range(0, 80) == 0) ? 1'b0 : 1'b1;
      settle();
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL random_%0d: got %h expected %h", c, got, exp_v);
      end
      next_cycle();
    end
    reset = 1'b1;
  endtask

  initial begin
    drive_idle();
    reset = 1'b0;
    m_frozen = 1'b0; m_replay_now = 1'b0; m_has_owed = 1'b0; m_owed_pc = 32'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_over_load_use();
    test_freeze_replay();
    test_jump();
    test_reset_in_freeze();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
